ysyx_22040386_csr_ctrl: RTL and testbench
=========================================

YSYX_22040386_CSR_CTRL -- requirements
Module: ysyx_22040386_csr_ctrl

Interface
REQ-001 SHALL have parameter MCAUSE_ECALL, default 64'd11, cause code written to mcause on ecall.
REQ-002 SHALL have parameter MSTATUS_RST, default 64'h0000_000A_0000_1800, mstatus reset value.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- i_CC_clk  in  1  clock.
- i_CC_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have the following request ports.
- i_CC_valid  in  1  request strobe, held by the requester until o_CC_done.
- i_CC_state  in  2  operation code: 00 idle, 01 RW, 10 ECALL, 11 MRET.
- i_CC_funct3  in  3  operation select: 001 csrrw, 010 csrrs.
- i_CC_csr_addr  in  12  CSR address.
- i_CC_wdata  in  64  rs1 data.
- i_CC_pc  in  64  PC of the trapping or CSR instruction.
REQ-005 SHALL have the following response ports.
- o_CC_busy  out  1  high in any non-IDLE state.
- o_CC_done  out  1  one-cycle completion pulse.
- o_CC_rdata  out  64  old CSR value, valid with o_CC_done.
- o_CC_redirect  out  1  PC redirect, valid with o_CC_done.
- o_CC_redirect_pc  out  64  redirect target.
- o_CC_illegal  out  1  unknown CSR address, valid with o_CC_done.

Function
REQ-006 SHALL hold these CSRs internally: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00.
REQ-007 SHALL implement FSM states IDLE, RW, E_SAVE, E_STAT, M_STAT and DONE.
REQ-008 SHALL, in IDLE with i_CC_valid=1, register all request inputs and move to RW, E_SAVE or M_STAT when i_CC_state is 01, 10 or 11 respectively.
REQ-009 SHALL ignore i_CC_state=00 and stay in IDLE.
REQ-010 SHALL ignore i_CC_valid in any state other than IDLE.
REQ-011 SHALL, in RW, capture the old CSR value into rdata and write it as follows: csrrw writes wdata; csrrs writes old|wdata, with no write when wdata==0; then go to DONE.
REQ-012 SHALL, in RW with an unknown address, capture rdata=0, perform no write, set illegal and go to DONE.
REQ-013 SHALL always read mip as 0 and ignore writes to it.
REQ-014 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write.
REQ-015 SHALL, in E_SAVE, set mepc<=pc with bits [1:0] forced to 0 and mcause<=MCAUSE_ECALL, then go to E_STAT.
REQ-016 SHALL, in E_STAT, set MPIE(bit 7)<=MIE(bit 3), MIE<=0 and MPP[12:11]<=2'b11, then go to DONE with redirect_pc=mtvec.
REQ-017 SHALL, in M_STAT, set MIE<=MPIE, MPIE<=1 and MPP<=2'b11, then go to DONE with redirect_pc=mepc.
REQ-018 SHALL, in DONE, assert done for exactly one cycle with rdata, illegal and redirect valid, then return to IDLE.
REQ-019 SHALL assert redirect only for ECALL and MRET.
REQ-020 SHALL drive done, redirect and illegal to 0 outside DONE.
REQ-021 SHALL give these latencies, counted from the acceptance edge to the done cycle: RW 2 cycles, MRET 2 cycles, ECALL 3 cycles.
REQ-022 SHALL increment mcycle by 1 every cycle with 64-bit wrap-around, with an RW write to mcycle taking priority over the increment in that cycle.
REQ-023 SHALL NOT let requester inputs changing after acceptance affect the operation in flight.

Reset
REQ-024 SHALL, on reset assertion, asynchronously set the state to IDLE and all outputs to 0.
REQ-025 SHALL, on reset, set mstatus=MSTATUS_RST and all other CSRs to 0.
REQ-026 SHALL abort any in-flight operation on reset, leaving no partial trap update after reset.

Verification
REQ-027 SHALL cover: csrrw 0x305 with wdata 0x8000_0103 -> done after 2 cycles, rdata=0; then csrrs 0x305 with wdata 0 -> rdata=0x8000_0100.
REQ-028 SHALL cover: mtvec=0x8000_0100, MIE=1, ECALL with pc=0x8000_0042 -> done after 3 cycles, redirect=1, redirect_pc=0x8000_0100, mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1, MPP=3.
REQ-029 SHALL cover: MRET following the ECALL scenario -> done after 2 cycles, redirect_pc=0x8000_0040, MIE=1, MPIE=1.
REQ-030 SHALL cover: csrrw 0xB00 with wdata 0, then csrrs 0xB00 with wdata 0 accepted k cycles later -> rdata equals k plus the fixed pipeline offset; a read after wrap from 0xFFFF_FFFF_FFFF_FFFF shows 0.
REQ-031 SHALL cover: csrrw 0x7C0 with wdata 5 -> illegal=1, rdata=0, all CSRs except mcycle unchanged.
REQ-032 SHALL cover: reset asserted while in E_STAT -> outputs 0 immediately, and after release mstatus=MSTATUS_RST, mepc=0, busy=0.

Source files
------------

// File: rtl/ysyx_22040386_csr_ctrl.sv
// Machine-mode CSR controller: csrrw/csrrs accesses, ECALL trap entry and MRET return
// sequenced by a small FSM, plus a free-running mcycle counter.
module ysyx_22040386_csr_ctrl #(
    parameter logic [63:0] MCAUSE_ECALL = 64'd11,
    parameter logic [63:0] MSTATUS_RST  = 64'h0000_000A_0000_1800
) (
    input  logic        i_CC_clk,
    input  logic        i_CC_rst,
    input  logic        i_CC_valid,
    input  logic [1:0]  i_CC_state,
    input  logic [2:0]  i_CC_funct3,
    input  logic [11:0] i_CC_csr_addr,
    input  logic [63:0] i_CC_wdata,
    input  logic [63:0] i_CC_pc,
    output logic        o_CC_busy,
    output logic        o_CC_done,
    output logic [63:0] o_CC_rdata,
    output logic        o_CC_redirect,
    output logic [63:0] o_CC_redirect_pc,
    output logic        o_CC_illegal
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [63:0] ALIGN_MASK   = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RW     = 3'd1,
        S_E_SAVE = 3'd2,
        S_E_STAT = 3'd3,
        S_M_STAT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [11:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] pc_q, pc_d;

    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] mie_q, mie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] rdata_q, rdata_d;
    logic        redirect_q, redirect_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;
    logic        illegal_q, illegal_d;

    logic [63:0] csr_old_s;
    logic        csr_hit_s;
    logic        wr_en_s;
    logic [63:0] wval_s;

    // CSR read mux on the latched address; mip is a hit that always reads zero
    always_comb begin
        csr_old_s = 64'd0;
        csr_hit_s = 1'b1;
        case (addr_q)
            CSR_MSTATUS:  csr_old_s = mstatus_q;
            CSR_MIE:      csr_old_s = mie_q;
            CSR_MTVEC:    csr_old_s = mtvec_q;
            CSR_MSCRATCH: csr_old_s = mscratch_q;
            CSR_MEPC:     csr_old_s = mepc_q;
            CSR_MCAUSE:   csr_old_s = mcause_q;
            CSR_MIP:      csr_old_s = 64'd0;
            CSR_MCYCLE:   csr_old_s = mcycle_q;
            default:      csr_hit_s = 1'b0;
        endcase
    end

    // Write enable and value for the RW step; csrrs with a zero mask is a pure read
    always_comb begin
        wr_en_s = 1'b0;
        wval_s  = 64'd0;
        if ((state_q == S_RW) && csr_hit_s) begin
            case (funct3_q)
                3'b001: begin
                    wr_en_s = 1'b1;
                    wval_s  = wdata_q;
                end
                3'b010: begin
                    wr_en_s = (wdata_q != 64'd0);
                    wval_s  = csr_old_s | wdata_q;
                end
                default: begin
                    wr_en_s = 1'b0;
                    wval_s  = 64'd0;
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
            wval_s  = 64'd0;
        end
    end

    // CSR next-state: software writes, trap entry/return updates and the cycle counter
    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        if (wr_en_s) begin
            case (addr_q)
                CSR_MSTATUS:  mstatus_d  = wval_s;
                CSR_MIE:      mie_d      = wval_s;
                CSR_MTVEC:    mtvec_d    = wval_s & ALIGN_MASK;
                CSR_MSCRATCH: mscratch_d = wval_s;
                CSR_MEPC:     mepc_d     = wval_s & ALIGN_MASK;
                CSR_MCAUSE:   mcause_d   = wval_s;
                CSR_MCYCLE:   mcycle_d   = wval_s;
                default:      mcause_d   = mcause_q;
            endcase
        end else begin
            mcause_d = mcause_q;
        end
        case (state_q)
            S_E_SAVE: begin
                mepc_d   = pc_q & ALIGN_MASK;
                mcause_d = MCAUSE_ECALL;
            end
            S_E_STAT: begin
                mstatus_d[7]     = mstatus_q[3];
                mstatus_d[3]     = 1'b0;
                mstatus_d[12:11] = 2'b11;
            end
            S_M_STAT: begin
                mstatus_d[3]     = mstatus_q[7];
                mstatus_d[7]     = 1'b1;
                mstatus_d[12:11] = 2'b11;
            end
            default: mstatus_d = mstatus_d;
        endcase
    end

    // Sequencing FSM; response outputs are computed here and registered on entry to DONE
    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        pc_d          = pc_q;
        rdata_d       = 64'd0;
        redirect_d    = 1'b0;
        redirect_pc_d = 64'd0;
        illegal_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_CC_valid) begin
                    funct3_d = i_CC_funct3;
                    addr_d   = i_CC_csr_addr;
                    wdata_d  = i_CC_wdata;
                    pc_d     = i_CC_pc;
                    case (i_CC_state)
                        2'b01:   state_d = S_RW;
                        2'b10:   state_d = S_E_SAVE;
                        2'b11:   state_d = S_M_STAT;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RW: begin
                rdata_d   = csr_old_s;
                illegal_d = ~csr_hit_s;
                state_d   = S_DONE;
            end
            S_E_SAVE: state_d = S_E_STAT;
            S_E_STAT: begin
                redirect_d    = 1'b1;
                redirect_pc_d = mtvec_q;
                state_d       = S_DONE;
            end
            S_M_STAT: begin
                redirect_d    = 1'b1;
                redirect_pc_d = mepc_q;
                state_d       = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // FSM, request latch and registered response outputs
    always_ff @(posedge i_CC_clk or posedge i_CC_rst) begin
        if (i_CC_rst) begin
            state_q       <= S_IDLE;
            funct3_q      <= 3'd0;
            addr_q        <= 12'd0;
            wdata_q       <= 64'd0;
            pc_q          <= 64'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= 64'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 64'd0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            pc_q          <= pc_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            illegal_q     <= illegal_d;
        end
    end

    // CSR storage
    always_ff @(posedge i_CC_clk or posedge i_CC_rst) begin
        if (i_CC_rst) begin
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= 64'd0;
            mtvec_q    <= 64'd0;
            mscratch_q <= 64'd0;
            mepc_q     <= 64'd0;
            mcause_q   <= 64'd0;
            mcycle_q   <= 64'd0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

    assign o_CC_busy        = busy_q;
    assign o_CC_done        = done_q;
    assign o_CC_rdata       = rdata_q;
    assign o_CC_redirect    = redirect_q;
    assign o_CC_redirect_pc = redirect_pc_q;
    assign o_CC_illegal     = illegal_q;

endmodule

// File: tb/tb_ysyx_22040386_csr_ctrl.sv
// Directed self-checking bench for ysyx_22040386_csr_ctrl: CSR access, ECALL/MRET,
// mcycle counting and wrap, illegal addresses and reset during a trap.
module tb_ysyx_22040386_csr_ctrl;

    logic        clk;
    logic        rst;
    logic        i_CC_valid;
    logic [1:0]  i_CC_state;
    logic [2:0]  i_CC_funct3;
    logic [11:0] i_CC_csr_addr;
    logic [63:0] i_CC_wdata;
    logic [63:0] i_CC_pc;
    logic        o_CC_busy;
    logic        o_CC_done;
    logic [63:0] o_CC_rdata;
    logic        o_CC_redirect;
    logic [63:0] o_CC_redirect_pc;
    logic        o_CC_illegal;

    integer      checks;
    integer      errors;
    logic [63:0] edge_cnt;

    int          r_lat;
    logic [63:0] r_rdata;
    logic        r_redir;
    logic [63:0] r_rpc;
    logic        r_ill;
    logic [63:0] r_acc;

    localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;

    ysyx_22040386_csr_ctrl dut (
        .i_CC_clk         (clk),
        .i_CC_rst         (rst),
        .i_CC_valid       (i_CC_valid),
        .i_CC_state       (i_CC_state),
        .i_CC_funct3      (i_CC_funct3),
        .i_CC_csr_addr    (i_CC_csr_addr),
        .i_CC_wdata       (i_CC_wdata),
        .i_CC_pc          (i_CC_pc),
        .o_CC_busy        (o_CC_busy),
        .o_CC_done        (o_CC_done),
        .o_CC_rdata       (o_CC_rdata),
        .o_CC_redirect    (o_CC_redirect),
        .o_CC_redirect_pc (o_CC_redirect_pc),
        .o_CC_illegal     (o_CC_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 64'd1;

    // Issue one request once the block is idle, scramble inputs after acceptance,
    // and record the latency (edges from acceptance to the done cycle) and the response.
    task automatic do_req(input logic [1:0] st, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [63:0] wd, input logic [63:0] pc);
        int guard;
        logic found;
        guard = 0;
        found = 1'b0;
        @(negedge clk);
        while (o_CC_busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        i_CC_valid    = 1'b1;
        i_CC_state    = st;
        i_CC_funct3   = f3;
        i_CC_csr_addr = addr;
        i_CC_wdata    = wd;
        i_CC_pc       = pc;
        @(posedge clk);
        #1;
        r_acc   = edge_cnt;
        r_lat   = 1;
        r_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        r_redir = 1'b0;
        r_rpc   = 64'd0;
        r_ill   = 1'b0;
        i_CC_state    = ~st;
        i_CC_funct3   = ~f3;
        i_CC_csr_addr = ~addr;
        i_CC_wdata    = ~wd;
        i_CC_pc       = ~pc;
        while (!found && r_lat < 20) begin
            @(posedge clk);
            r_lat++;
            #1;
            if (o_CC_done) begin
                found   = 1'b1;
                r_rdata = o_CC_rdata;
                r_redir = o_CC_redirect;
                r_rpc   = o_CC_redirect_pc;
                r_ill   = o_CC_illegal;
            end
        end
        if (!found) r_lat = -1;
        i_CC_valid = 1'b0;
        i_CC_state = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_CC_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_CC_busy); end
        checks++; if (o_CC_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", o_CC_done); end
        checks++; if ({o_CC_redirect, o_CC_illegal} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b%b exp 00", o_CC_redirect, o_CC_illegal); end
        checks++; if ({o_CC_rdata, o_CC_redirect_pc} !== 128'd0) begin errors++; $display("FAIL rst_data got %h %h exp 0", o_CC_rdata, o_CC_redirect_pc); end
        @(negedge clk);
        rst = 1'b0;
        do_req(2'b01, 3'b010, 12'h300, 64'd0, 64'd0);
        checks++; if (r_rdata !== MSTATUS_RST) begin errors++; $display("FAIL rst_mstatus got %h exp %h", r_rdata, MSTATUS_RST); end
        do_req(2'b01, 3'b010, 12'h305, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'd0) begin errors++; $display("FAIL rst_mtvec got %h exp 0", r_rdata); end
    endtask

    task automatic test_idle_ignore;
        @(negedge clk);
        i_CC_valid = 1'b1;
        i_CC_state = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if ({o_CC_busy, o_CC_done} !== 2'b00) begin errors++; $display("FAIL idle_ignore got busy/done %b%b exp 00", o_CC_busy, o_CC_done); end
        end
        i_CC_valid = 1'b0;
    endtask

    task automatic test_csrrw_mtvec;
        do_req(2'b01, 3'b001, 12'h305, 64'h0000_0000_8000_0103, 64'd0);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL rw_latency got %0d exp 2", r_lat); end
        checks++; if (r_rdata !== 64'd0) begin errors++; $display("FAIL rw_old got %h exp 0", r_rdata); end
        checks++; if ({r_redir, r_ill} !== 2'b00) begin errors++; $display("FAIL rw_flags got %b%b exp 00", r_redir, r_ill); end
        @(posedge clk);
        #1;
        checks++; if (o_CC_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", o_CC_done); end
        do_req(2'b01, 3'b010, 12'h305, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'h0000_0000_8000_0100) begin errors++; $display("FAIL mtvec_align got %h exp 80000100", r_rdata); end
    endtask

    task automatic test_csrrs_mscratch_mip;
        do_req(2'b01, 3'b001, 12'h340, 64'h0000_0000_0000_00F0, 64'd0);
        do_req(2'b01, 3'b010, 12'h340, 64'h0000_0000_0000_000F, 64'd0);
        checks++; if (r_rdata !== 64'h0000_0000_0000_00F0) begin errors++; $display("FAIL csrrs_old got %h exp f0", r_rdata); end
        do_req(2'b01, 3'b010, 12'h340, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'h0000_0000_0000_00FF) begin errors++; $display("FAIL csrrs_set got %h exp ff", r_rdata); end
        do_req(2'b01, 3'b001, 12'h344, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        do_req(2'b01, 3'b010, 12'h344, 64'd0, 64'd0);
        checks++; if ({r_rdata, r_ill} !== 65'd0) begin errors++; $display("FAIL mip_zero got %h ill %b exp 0", r_rdata, r_ill); end
    endtask

    task automatic test_ecall;
        do_req(2'b01, 3'b010, 12'h300, 64'h0000_0000_0000_0008, 64'd0);
        do_req(2'b10, 3'b000, 12'h000, 64'd0, 64'h0000_0000_8000_0042);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL ecall_latency got %0d exp 3", r_lat); end
        checks++; if (r_redir !== 1'b1) begin errors++; $display("FAIL ecall_redirect got %b exp 1", r_redir); end
        checks++; if (r_rpc !== 64'h0000_0000_8000_0100) begin errors++; $display("FAIL ecall_target got %h exp 80000100", r_rpc); end
        do_req(2'b01, 3'b010, 12'h341, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'h0000_0000_8000_0040) begin errors++; $display("FAIL ecall_mepc got %h exp 80000040", r_rdata); end
        do_req(2'b01, 3'b010, 12'h342, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'd11) begin errors++; $display("FAIL ecall_mcause got %h exp b", r_rdata); end
        do_req(2'b01, 3'b010, 12'h300, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'h0000_000A_0000_1880) begin errors++; $display("FAIL ecall_mstatus got %h exp a00001880", r_rdata); end
    endtask

    task automatic test_mret;
        do_req(2'b11, 3'b000, 12'h000, 64'd0, 64'd0);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL mret_latency got %0d exp 2", r_lat); end
        checks++; if ({r_redir, r_rpc} !== {1'b1, 64'h0000_0000_8000_0040}) begin errors++; $display("FAIL mret_target got %b %h exp 1 80000040", r_redir, r_rpc); end
        do_req(2'b01, 3'b010, 12'h300, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'h0000_000A_0000_1888) begin errors++; $display("FAIL mret_mstatus got %h exp a00001888", r_rdata); end
    endtask

    task automatic test_mcycle;
        logic [63:0] acc1;
        logic [63:0] expv;
        do_req(2'b01, 3'b001, 12'hB00, 64'd0, 64'd0);
        acc1 = r_acc;
        repeat (4) @(posedge clk);
        do_req(2'b01, 3'b010, 12'hB00, 64'd0, 64'd0);
        expv = r_acc - acc1 - 64'd1;
        checks++; if (r_rdata !== expv) begin errors++; $display("FAIL mcycle_count got %h exp %h", r_rdata, expv); end
        do_req(2'b01, 3'b001, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        acc1 = r_acc;
        do_req(2'b01, 3'b010, 12'hB00, 64'd0, 64'd0);
        expv = 64'hFFFF_FFFF_FFFF_FFFE + (r_acc - acc1) - 64'd1;
        checks++; if (r_rdata !== expv) begin errors++; $display("FAIL mcycle_wrap got %h exp %h", r_rdata, expv); end
        checks++; if (r_acc - acc1 !== 64'd3) begin errors++; $display("FAIL b2b_accept_gap got %0d exp 3", r_acc - acc1); end
    endtask

    task automatic test_illegal;
        do_req(2'b01, 3'b001, 12'h7C0, 64'd5, 64'd0);
        checks++; if ({r_ill, r_redir} !== 2'b10) begin errors++; $display("FAIL illegal_flags got %b%b exp 10", r_ill, r_redir); end
        checks++; if (r_rdata !== 64'd0) begin errors++; $display("FAIL illegal_rdata got %h exp 0", r_rdata); end
        do_req(2'b01, 3'b010, 12'h305, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'h0000_0000_8000_0100) begin errors++; $display("FAIL illegal_mtvec got %h exp 80000100", r_rdata); end
        do_req(2'b01, 3'b010, 12'h340, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'h0000_0000_0000_00FF) begin errors++; $display("FAIL illegal_mscratch got %h exp ff", r_rdata); end
        do_req(2'b01, 3'b010, 12'h300, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'h0000_000A_0000_1888) begin errors++; $display("FAIL illegal_mstatus got %h exp a00001888", r_rdata); end
    endtask

    task automatic test_reset_in_estat;
        @(negedge clk);
        i_CC_valid = 1'b1;
        i_CC_state = 2'b10;
        i_CC_pc    = 64'h0000_0000_8000_1234;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++; if (o_CC_busy !== 1'b1) begin errors++; $display("FAIL estat_busy got %b exp 1", o_CC_busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({o_CC_busy, o_CC_done, o_CC_redirect, o_CC_illegal} !== 4'b0000) begin errors++; $display("FAIL async_rst_flags got %b%b%b%b exp 0000", o_CC_busy, o_CC_done, o_CC_redirect, o_CC_illegal); end
        i_CC_valid = 1'b0;
        i_CC_state = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (o_CC_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b exp 0", o_CC_busy); end
        do_req(2'b01, 3'b010, 12'h300, 64'd0, 64'd0);
        checks++; if (r_rdata !== MSTATUS_RST) begin errors++; $display("FAIL post_rst_mstatus got %h exp %h", r_rdata, MSTATUS_RST); end
        do_req(2'b01, 3'b010, 12'h341, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'd0) begin errors++; $display("FAIL post_rst_mepc got %h exp 0", r_rdata); end
        do_req(2'b01, 3'b010, 12'h342, 64'd0, 64'd0);
        checks++; if (r_rdata !== 64'd0) begin errors++; $display("FAIL post_rst_mcause got %h exp 0", r_rdata); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        edge_cnt      = 64'd0;
        rst           = 1'b1;
        i_CC_valid    = 1'b0;
        i_CC_state    = 2'b00;
        i_CC_funct3   = 3'b000;
        i_CC_csr_addr = 12'h000;
        i_CC_wdata    = 64'd0;
        i_CC_pc       = 64'd0;
        r_lat         = 0;
        r_rdata       = 64'd0;
        r_redir       = 1'b0;
        r_rpc         = 64'd0;
        r_ill         = 1'b0;
        r_acc         = 64'd0;
        test_reset();
        test_idle_ignore();
        test_csrrw_mtvec();
        test_csrrs_mscratch_mip();
        test_ecall();
        test_mret();
        test_mcycle();
        test_illegal();
        test_reset_in_estat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
